// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: fetch/decode/execute sequencer for the 16-bit datapath.
// Controls are decoded from the registered state and ir; memory handshakes gate completion.
module multicycle_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        instr_in,
    input  logic                     mem_ready,
    input  logic [4:0]               flags,
    output logic [DATA_W-1:0]        ir,
    output logic [REG_AW-1:0]        ra_sel,
    output logic [REG_AW-1:0]        rb_sel,
    output logic                     imm_sel,
    output logic [(1<<REG_AW)-1:0]   reg_wr_en,
    output logic [1:0]               wb_sel,
    output logic                     addr_sel,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic                     flag_en,
    output logic                     pc_inc,
    output logic                     pc_ld,
    output logic                     pc_src,
    output logic                     halted,
    output logic                     illegal,
    output logic [3:0]               state_out
);

    localparam int unsigned NUM_REGS = 1 << REG_AW;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_LOAD   = 4'd4,
        S_STORE  = 4'd5,
        S_JUMP   = 4'd6,
        S_HALT   = 4'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_W-1:0]     r_ir;
    logic                  r_illegal;
    logic                  w_set_illegal;
    logic [3:0]            w_op;
    logic [3:0]            w_ext;
    logic [3:0]            w_cond;
    logic                  w_is_cmp;
    logic                  w_is_jal;
    logic                  w_cond_ok;
    logic [NUM_REGS-1:0]   w_ra_onehot;

    assign w_op        = r_ir[15:12];
    assign w_ext       = r_ir[7:4];
    assign w_cond      = r_ir[11:8];
    assign w_is_jal    = (w_op == 4'h4) && (w_ext == 4'h8);
    assign w_is_cmp    = (w_op == 4'h0) ? ((w_ext == 4'hB) || (w_ext == 4'hF))
                                        : ((w_op == 4'hB) || (w_op == 4'hF));
    assign w_ra_onehot = NUM_REGS'(1) << r_ir[11:8];

    assign ir        = r_ir;
    assign illegal   = r_illegal;
    assign state_out = 4'(r_state);
    assign ra_sel    = REG_AW'(r_ir[11:8]);
    assign rb_sel    = REG_AW'(r_ir[3:0]);

    // Branch/jump condition from {Z,C,F,N,L}
    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'h0: w_cond_ok = flags[4];
            4'h1: w_cond_ok = !flags[4];
            4'h2: w_cond_ok = flags[3];
            4'h3: w_cond_ok = !flags[3];
            4'h4: w_cond_ok = flags[0];
            4'h5: w_cond_ok = !flags[0];
            4'h6: w_cond_ok = flags[1];
            4'h7: w_cond_ok = !flags[1];
            4'h8: w_cond_ok = flags[2];
            4'h9: w_cond_ok = !flags[2];
            4'hA: w_cond_ok = !flags[0] && !flags[4];
            4'hB: w_cond_ok = flags[0] || flags[4];
            4'hC: w_cond_ok = !flags[1] && !flags[4];
            4'hD: w_cond_ok = flags[1] || flags[4];
            4'hE: w_cond_ok = 1'b1;
            4'hF: w_cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RESET;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && mem_ready)
                r_ir <= instr_in;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    // Next state and control decode; everything held inactive during reset
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        imm_sel       = 1'b0;
        reg_wr_en     = '0;
        wb_sel        = 2'b00;
        addr_sel      = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        flag_en       = 1'b0;
        pc_inc        = 1'b0;
        pc_ld         = 1'b0;
        pc_src        = 1'b0;
        halted        = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_RESET: w_next = S_FETCH;
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        pc_inc = 1'b1;
                        w_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_ir[15:0] == 16'h0000) begin
                        w_next = S_HALT;
                    end else begin
                        case (w_op)
                            4'h0: w_next = S_EXEC;
                            4'h4: begin
                                case (w_ext)
                                    4'h0:       w_next = S_LOAD;
                                    4'h4:       w_next = S_STORE;
                                    4'h8, 4'hC: w_next = S_JUMP;
                                    default: begin
                                        w_next        = S_HALT;
                                        w_set_illegal = 1'b1;
                                    end
                                endcase
                            end
                            4'hC:    w_next = S_JUMP;
                            default: w_next = S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    flag_en   = 1'b1;
                    imm_sel   = (w_op != 4'h0);
                    reg_wr_en = w_is_cmp ? '0 : w_ra_onehot;
                    w_next    = S_FETCH;
                end
                S_LOAD: begin
                    mem_rd   = 1'b1;
                    addr_sel = 1'b1;
                    wb_sel   = 2'b01;
                    if (mem_ready) begin
                        reg_wr_en = w_ra_onehot;
                        w_next    = S_FETCH;
                    end
                end
                S_STORE: begin
                    mem_wr   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ready)
                        w_next = S_FETCH;
                end
                S_JUMP: begin
                    pc_src = (w_op == 4'hC);
                    if (w_is_jal) begin
                        pc_ld     = 1'b1;
                        reg_wr_en = w_ra_onehot;
                        wb_sel    = 2'b10;
                    end else begin
                        pc_ld = w_cond_ok;
                    end
                    w_next = S_FETCH;
                end
                S_HALT:  halted = 1'b1;
                default: w_next = S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors vs. observed outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        mem_ready;
    logic [4:0]  flags;
    logic [15:0] ir;
    logic [3:0]  ra_sel, rb_sel;
    logic        imm_sel;
    logic [15:0] reg_wr_en;
    logic [1:0]  wb_sel;
    logic        addr_sel, mem_rd, mem_wr, flag_en, pc_inc, pc_ld, pc_src, halted, illegal;
    logic [3:0]  state_out;

    multicycle_ctrl #(.DATA_W(16), .REG_AW(4)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready), .flags(flags),
        .ir(ir), .ra_sel(ra_sel), .rb_sel(rb_sel), .imm_sel(imm_sel), .reg_wr_en(reg_wr_en),
        .wb_sel(wb_sel), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .flag_en(flag_en),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_src(pc_src), .halted(halted), .illegal(illegal),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ir;
        logic [3:0]  ra, rb;
        logic        imm;
        logic [15:0] we;
        logic [1:0]  wb;
        logic        asel, rd, wr, fen, inc, ld, src, hlt, ill;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        obs_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_ir  = '0;
    logic        m_ill = 1'b0;

    function automatic obs_t blank(input logic [3:0] st, input logic [15:0] i);
        obs_t o = '0;
        o.st = st; o.ir = i; o.ra = i[11:8]; o.rb = i[3:0]; o.ill = m_ill;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state_out; o.ir = ir; o.ra = ra_sel; o.rb = rb_sel; o.imm = imm_sel;
        o.we = reg_wr_en; o.wb = wb_sel; o.asel = addr_sel; o.rd = mem_rd; o.wr = mem_wr;
        o.fen = flag_en; o.inc = pc_inc; o.ld = pc_ld; o.src = pc_src; o.hlt = halted;
        o.ill = illegal;
        return o;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] f);
        logic z, cy, fl, n, l;
        z = f[4]; cy = f[3]; fl = f[2]; n = f[1]; l = f[0];
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return l;          4'h5: return !l;
            4'h6: return n;          4'h7: return !n;
            4'h8: return fl;         4'h9: return !fl;
            4'hA: return !l && !z;   4'hB: return l || z;
            4'hC: return !n && !z;   4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Invariants checked every non-reset cycle
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((pc_inc && pc_ld) || (mem_rd && mem_wr)) begin
                errors++;
                $display("FAIL exclusive inc=%b ld=%b rd=%b wr=%b required no overlap",
                         pc_inc, pc_ld, mem_rd, mem_wr);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        obs_q.push_back(sample());
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction from FETCH to completion, pushing expected vectors per cycle
    task automatic issue(input logic [15:0] instr, input logic [4:0] fl, input int fwait, input int mwait);
        obs_t e;
        logic [3:0] op, ext;
        op = instr[15:12];
        ext = instr[7:4];
        instr_in = instr;
        flags = fl;
        for (int i = 0; i < fwait; i++) begin
            mem_ready = 1'b0;
            e = blank(4'd1, m_ir); e.rd = 1'b1;
            exp_q.push_back(e); cyc();
        end
        mem_ready = 1'b1;
        e = blank(4'd1, m_ir); e.rd = 1'b1; e.inc = 1'b1;
        exp_q.push_back(e); cyc();
        m_ir = instr;
        mem_ready = 1'($urandom);
        exp_q.push_back(blank(4'd2, m_ir)); cyc();
        if (instr == 16'h0000 || (op == 4'h4 && !(ext inside {4'h0, 4'h4, 4'h8, 4'hC}))) begin
            if (instr != 16'h0000) m_ill = 1'b1;
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'($urandom);
                e = blank(4'd7, m_ir); e.hlt = 1'b1;
                exp_q.push_back(e); cyc();
            end
        end else if (op == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
            for (int i = 0; i <= mwait; i++) begin
                mem_ready = (i == mwait);
                e = blank((ext == 4'h0) ? 4'd4 : 4'd5, m_ir); e.asel = 1'b1;
                if (ext == 4'h0) begin
                    e.rd = 1'b1; e.wb = 2'b01;
                    if (i == mwait) e.we = 16'h0001 << instr[11:8];
                end else begin
                    e.wr = 1'b1;
                end
                exp_q.push_back(e); cyc();
            end
        end else if (op == 4'h4 || op == 4'hC) begin
            mem_ready = 1'($urandom);
            e = blank(4'd6, m_ir); e.src = (op == 4'hC);
            if (op == 4'h4 && ext == 4'h8) begin
                e.ld = 1'b1; e.we = 16'h0001 << instr[11:8]; e.wb = 2'b10;
            end else begin
                e.ld = cond_ok(instr[11:8], fl);
            end
            exp_q.push_back(e); cyc();
        end else begin
            mem_ready = 1'($urandom);
            e = blank(4'd3, m_ir); e.fen = 1'b1; e.imm = (op != 4'h0);
            if (!((op == 4'h0) ? (ext inside {4'hB, 4'hF}) : (op inside {4'hB, 4'hF})))
                e.we = 16'h0001 << instr[11:8];
            exp_q.push_back(e); cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; instr_in = '0; flags = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_ir = '0; m_ill = 1'b0;
        exp_q.push_back(blank(4'd0, 16'h0000)); cyc();
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL reset got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_alu();
        issue(16'h0355, 5'h00, 0, 0);
        checks++;
        if (obs_q[2].we !== 16'h0008 || obs_q[2].fen !== 1'b1) begin
            errors++; $display("FAIL add_exec we=%h fen=%b want we=0008 fen=1", obs_q[2].we, obs_q[2].fen);
        end
        issue(16'h0355, 5'h00, 2, 0);
        issue(16'h01B2, 5'h00, 0, 0);
        issue(16'h5312, 5'h00, 1, 0);
        issue(16'hB105, 5'h00, 0, 0);
        issue(16'h07F4, 5'h00, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL alu got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_load();
        issue(16'h4207, 5'h00, 0, 3);
        checks++;
        if (obs_q[5].we !== 16'h0004 || obs_q[4].we !== 16'h0000 || obs_q[4].rd !== 1'b1) begin
            errors++; $display("FAIL load_ready we=%h/%h want 0000/0004", obs_q[4].we, obs_q[5].we);
        end
        issue(16'h4A01, 5'h00, 1, 0);
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL load got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_store();
        issue(16'h4346, 5'h00, 0, 2);
        issue(16'h4F40, 5'h00, 0, 0);
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL store got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_jumps();
        issue(16'h4E89, 5'h00, 0, 0);
        checks++;
        if (obs_q[2].we !== 16'h4000 || obs_q[2].wb !== 2'b10 || obs_q[2].ld !== 1'b1 || obs_q[2].src !== 1'b0) begin
            errors++; $display("FAIL jal we=%h wb=%b want 4000 10", obs_q[2].we, obs_q[2].wb);
        end
        for (int c = 0; c < 16; c++)
            issue({4'h4, 4'(c), 4'hC, 4'(c)}, 5'($urandom), 0, 0);
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL jump got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_branch_sweep();
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 32; f++)
                issue({4'hC, 4'(c), 8'hFC}, 5'(f), 0, 0);
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL bcond got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_store_reset();
        obs_t e;
        instr_in = 16'h4346; mem_ready = 1'b1;
        e = blank(4'd1, m_ir); e.rd = 1'b1; e.inc = 1'b1;
        exp_q.push_back(e); cyc();
        m_ir = 16'h4346; mem_ready = 1'b0;
        exp_q.push_back(blank(4'd2, m_ir)); cyc();
        e = blank(4'd5, m_ir); e.wr = 1'b1; e.asel = 1'b1;
        exp_q.push_back(e); cyc();
        reset = 1'b1;
        exp_q.push_back(blank(4'd5, m_ir)); cyc();
        reset = 1'b0; m_ir = '0; m_ill = 1'b0;
        exp_q.push_back(blank(4'd0, 16'h0000)); cyc();
        e = blank(4'd1, 16'h0000); e.rd = 1'b1;
        exp_q.push_back(e); cyc();
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL store_reset got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_halt();
        issue(16'h0000, 5'h1F, 0, 0);
        for (int i = 0; i < 4; i++) begin
            obs_t e;
            mem_ready = 1'($urandom); instr_in = 16'(i + 1);
            e = blank(4'd7, m_ir); e.hlt = 1'b1;
            exp_q.push_back(e); cyc();
        end
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL halt got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_illegal();
        test_reset();
        issue(16'h4030, 5'h00, 0, 0);
        checks++;
        if (obs_q[1].ill !== 1'b0 || obs_q[2].ill !== 1'b1 || obs_q[2].hlt !== 1'b1) begin
            errors++; $display("FAIL illegal_sticky ill=%b/%b want 0/1", obs_q[1].ill, obs_q[2].ill);
        end
        while (exp_q.size() > 0) begin
            obs_t w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== w) begin errors++; $display("FAIL illegal got=%h want=%h", g, w); end
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; instr_in = '0; flags = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jumps();
        test_branch_sweep();
        test_store_reset();
        test_halt();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the 16-bit datapath: fetches an instruction over a ready-handshaked memory port, decodes it, and drives register-file, ALU, flag, memory and PC controls for R-type, immediate, load, store, conditional jump, conditional branch, jump-and-link and halt. It sits between the unified memory and the regfile/ALU/PC datapath. It generalises register count and data width and adds memory wait states, link writeback and illegal-op trapping.

## Interface

- DATA_W, 16, datapath/instruction-word width (≥16; instruction fields live in bits [15:0])
- REG_AW, 4, register address width; NUM_REGS = 2**REG_AW
- Note: instruction register fields are 4 bits, so REG_AW > 4 zero-extends register selects.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr_in  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the current read/write this cycle
- flags  in  5  {Z,C,F,N,L} at bits 4,3,2,1,0
- ir  out  DATA_W  latched instruction, to ALU opcode decode
- ra_sel  out  REG_AW  A operand / destination, ir[11:8]
- rb_sel  out  REG_AW  B operand / address register, ir[3:0]
- imm_sel  out  1  ALU B = sign-extended ir[7:0]
- reg_wr_en  out  NUM_REGS  one-hot register write enable
- wb_sel  out  2  00 ALU, 01 memory, 10 PC (link)
- addr_sel  out  1  memory address: 0 PC, 1 register rb
- mem_rd, mem_wr  out  1  memory read/write request
- flag_en  out  1  latch ALU flags
- pc_inc  out  1  PC ← PC+1
- pc_ld  out  1  PC load
- pc_src  out  1  0 register rb, 1 PC + sign-extended ir[7:0]
- halted  out  1  HALT state
- illegal  out  1  sticky, set on undefined op
- state_out  out  4  current state (debug)

## Operation

- Decode: op=ir[15:12], ext=ir[7:4]. op 0000 = R-type (ext = ALU function); op 0100: ext 0000 LOAD, 0100 STOR, 1100 Jcond, 1000 JAL (rdest ← PC, PC ← rb), other ext illegal; op 1100 = Bcond (cond ir[11:8], disp ir[7:0]); all other ops = I-type ALU. Instruction 0 = HALT.
- CMP (ext/op 1011) and CMPU (1111) update flags only: reg_wr_en = 0.
- Conditions: 0000 Z; 0001 !Z; 1101 N|Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 1010 !L&!Z; 1011 L|Z; 0110 N; 0111 !N; 1000 F; 1001 !F; 1100 !N&!Z; 1110 always; 1111 never.
- States (state_out): RESET 0, FETCH 1, DECODE 2, EXEC 3, LOAD 4, STORE 5, JUMP 6, HALT 7.
- RESET → FETCH next cycle.
- FETCH: mem_rd=1, addr_sel=0; holds while mem_ready=0; on mem_ready=1: ir ← instr_in, pc_inc=1, → DECODE.
- DECODE: no side effects; → HALT (zero or illegal, illegal set for the latter), EXEC, LOAD, STORE or JUMP.
- EXEC: ra/rb/imm_sel driven, flag_en=1, reg_wr_en one-hot(ir[11:8]) unless CMP/CMPU, wb_sel=00; → FETCH.
- LOAD: mem_rd=1, addr_sel=1, wb_sel=01; reg_wr_en one-hot(ra) only in the cycle mem_ready=1; → FETCH then.
- STORE: mem_wr=1, addr_sel=1, write data = reg ra; held until mem_ready=1; → FETCH.
- JUMP: pc_ld = condition (JAL: 1); pc_src=1 for Bcond, 0 otherwise; JAL also reg_wr_en one-hot(ra), wb_sel=10; → FETCH.
- HALT: all enables 0, halted=1; left only by reset.

## Timing

- All outputs are decoded from registered state and ir; pc_inc, LOAD reg_wr_en and the FETCH ir capture are additionally gated by mem_ready.
- Reset value: state RESET, ir 0, illegal 0, every enable/request 0, selects 0, halted 0.
- Reset wins over every state, including mid-wait in FETCH/LOAD/STORE; no write completes in the reset cycle.
- Latency with zero wait: ALU 3 cycles, LOAD/STORE/JUMP 3 cycles; each wait cycle adds one.
- Branch displacement is relative to the already-incremented PC (address+1).
- pc_inc and pc_ld never assert in the same cycle.
- mem_rd and mem_wr are mutually exclusive; requests stay asserted, address stable, until mem_ready.

## Test plan

- ADD r3,r5 (0x0355), mem_ready=1 → states 1,2,3; EXEC: reg_wr_en=0x0008, ra_sel=3, rb_sel=5, flag_en=1, pc_inc pulsed once in FETCH.
- CMP r1,r2 (0x01B2) → flag_en=1, reg_wr_en=0 in EXEC.
- LOAD r2,[r7] (0x4207), mem_ready low 3 cycles in LOAD → mem_rd held 4 cycles, addr_sel=1, reg_wr_en=0x0004 only in the ready cycle.
- Bcond EQ disp -4 (0xC0FC): Z=1 → pc_ld=1, pc_src=1; Z=0 → pc_ld=0; sweep all 16 codes against all 32 flag patterns.
- JAL r14,r9 (0x4E89) → pc_ld=1, pc_src=0, reg_wr_en=0x4000, wb_sel=10.
- 0x0000 → HALT, halted=1 indefinitely; 0x4030 → HALT with illegal=1; reset asserted mid-STORE wait → mem_wr=0 next cycle, state 0.
